// File: rtl/lab_pkg.sv
// Shared constants for the lab board input path: board clock and the
// switch debounce interval, plus the debounce length in clock cycles
// derived from them.
package lab_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;

  // 20 ms at 50 MHz -> 1_000_000 cycles.
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser, mismatch counter and
// registered rise/fall pulses. A change on the synchronised input is only
// accepted after it has differed from the clean level for DEBOUNCE_CYCLES
// consecutive clocks; any return to the clean level restarts the count.
module debounce_bit
  import lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Last count value before acceptance; the counter never goes past it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Next-state logic: count consecutive mismatches, accept on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = CNT_ZERO;
      clean_d = s2_q;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers: synchroniser, counter, clean level and edge pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= CNT_ZERO;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean   = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  // A synchronised level that differs from the clean one is an unaccepted change.
  assign pending = s2_q ^ clean_q;

endmodule

// File: rtl/sw_debounce_sync.sv
// Board switch conditioner feeding the lab mux: one independent
// synchronise-and-debounce lane per switch bit, clean levels, one-cycle
// rise/fall pulses, and a settled flag that is high when no lane has a
// change waiting to be accepted.
module sw_debounce_sync
  import lab_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled
);

  logic [WIDTH-1:0] pending_s;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock  (clock),
      .reset  (reset),
      .raw    (sw_raw[g]),
      .clean  (sw_clean[g]),
      .rise   (sw_rise[g]),
      .fall   (sw_fall[g]),
      .pending(pending_s[g])
    );
  end

  // Settled only when every lane agrees with its synchronised input.
  assign settled = ~(|pending_s);

endmodule
